kamus_fetch_ctrl: RTL



---
 rtl/kamus_fetch_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/kamus_fetch_ctrl.sv
// ============================================================================
//  kamus_fetch_ctrl
//  IF-stage fetch sequencer: PC ownership, single-outstanding L1I handshake,
//  single-entry output register to ID, redirect with orphan-response kill.
//  Optional KAMUS_FETCH_PERF_EN adds fetch/redirect event counters.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module kamus_fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        stall_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
`ifdef KAMUS_FETCH_PERF_EN
    output logic [31:0] if_next_pc_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] redirect_cnt_o
`else
    output logic [31:0] if_next_pc_o
`endif
);

    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;
    localparam logic [31:0] c_boot_pc   = BOOT_ADDR & c_word_mask;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_kill;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_next_pc;

    logic        w_consume;
    logic        w_free;
    logic        w_req;
    logic        w_gnt;
    logic        w_land;

    assign w_consume = r_valid & ~stall_i;
    assign w_free    = ~r_valid | w_consume;
    assign w_gnt     = w_req & instr_gnt_i;
    assign w_land    = (r_state == S_WAIT) & instr_rvalid_i & ~r_kill & ~redirect_valid_i;

    // The request is held back while ID stalls on a full register, so a
    // response can only ever land into a free register. Once raised it stays
    // up until granted: the register cannot refill while in REQ.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fetch_en_i && w_free) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_req = w_free;
                if (w_req && instr_gnt_i) begin
                    w_state_nxt = S_WAIT;
                end else if (!w_req && !fetch_en_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (instr_rvalid_i) begin
                    if (redirect_valid_i || fetch_en_i) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_pc     <= c_boot_pc;
            r_req_pc <= c_boot_pc;
            r_kill   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_gnt) begin
                r_req_pc <= r_pc;
            end

            if (redirect_valid_i) begin
                r_pc <= redirect_addr_i & c_word_mask;
            end else if (w_land) begin
                r_pc <= r_req_pc + 32'd4;
            end

            // An outstanding transaction at redirect time returns stale data.
            if (redirect_valid_i &&
                (((r_state == S_WAIT) && !instr_rvalid_i) || w_gnt)) begin
                r_kill <= 1'b1;
            end else if ((r_state == S_WAIT) && instr_rvalid_i) begin
                r_kill <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid      <= 1'b0;
            r_instr      <= 32'd0;
            r_if_pc      <= 32'd0;
            r_if_next_pc <= 32'd0;
        end else begin
            if (redirect_valid_i) begin
                r_valid <= 1'b0;
            end else if (w_land) begin
                r_valid      <= 1'b1;
                r_instr      <= instr_rdata_i;
                r_if_pc      <= r_req_pc;
                r_if_next_pc <= r_req_pc + 32'd4;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef KAMUS_FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_redirect_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_cnt    <= 32'd0;
            r_redirect_cnt <= 32'd0;
        end else begin
            if (w_land) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (redirect_valid_i) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o    = r_fetch_cnt;
    assign redirect_cnt_o = r_redirect_cnt;
`endif

    assign instr_req_o  = w_req;
    assign instr_addr_o = r_pc;
    assign if_valid_o   = r_valid;
    assign if_instr_o   = r_instr;
    assign if_pc_o      = r_if_pc;
    assign if_next_pc_o = r_if_next_pc;

endmodule

`default_nettype wire
